// File: rtl/mano_main_if.sv
// Observation bundle for the 8-bit Mano-style basic computer: architectural
// registers, memory read port, timing decode and bus source/destination codes.
interface mano_main_if;
    logic [7:0] DR;
    logic [7:0] AC;
    logic [7:0] IR;
    logic [7:0] MEM;
    logic [3:0] PC;
    logic [3:0] AR;
    logic [7:0] Timer;
    logic [7:0] D;
    logic [2:0] OUTSEQ;
    logic [2:0] sel;
    logic [2:0] en;
    logic [7:0] I;
    logic       J;
    logic       E;

    modport master (
        output DR, AC, IR, MEM, PC, AR, Timer, D, OUTSEQ, sel, en, I, J, E
    );

    modport slave (
        input DR, AC, IR, MEM, PC, AR, Timer, D, OUTSEQ, sel, en, I, J, E
    );
endinterface

// File: rtl/mano_main.sv
// 8-bit Mano-style basic computer: 16x8 memory, fetch/decode/execute sequenced
// by a 3-bit timing counter; all state is observable through mano_main_if.
module mano_main #(
    parameter string        INIT_FILE  = "",
    // word k of the power-up image sits in bits [8k+7:8k]; word 3 is HLT (0x77)
    parameter logic [127:0] INIT_IMAGE = 128'h0000_0000_0000_0305_0000_0000_773A_1928
) (
    input  logic         CLK,
    input  logic         RST,
    mano_main_if.master  bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
        T4 = 3'd4, T5 = 3'd5, T6 = 3'd6, T7 = 3'd7
    } sc_e;

    typedef logic [15:0][7:0] image_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MWR  = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // Power-up memory image unpacked from INIT_IMAGE.
    function automatic image_t load_image();
        image_t img;
        for (int k = 0; k < 16; k++) begin
            img[k] = INIT_IMAGE[8*k +: 8];
        end
        return img;
    endfunction

    image_t     mem_r = load_image();

    logic [3:0] ar_r, pc_r;
    logic [7:0] dr_r, ac_r, ir_r;
    logic       e_r, j_r, s_r;
    sc_e        sc_r;

    logic [3:0] ar_next_s, pc_next_s;
    logic [7:0] dr_next_s, ac_next_s, ir_next_s;
    logic       e_next_s, j_next_s, s_next_s;
    sc_e        sc_next_s;

    logic [2:0] sel_s, en_s;
    logic [7:0] reg_op_s;
    logic       mem_we_s;
    logic [7:0] mem_wdata_s;
    logic [7:0] mem_rd_s;
    logic [8:0] sum_s;
    logic       d7_s;

    assign mem_rd_s = mem_r[ar_r];
    assign sum_s    = {1'b0, ac_r} + {1'b0, dr_r};
    assign d7_s     = (ir_r[6:4] == 3'd7);

    // Next-state and bus-control decode for the current timing step.
    always_comb begin
        ar_next_s   = ar_r;
        pc_next_s   = pc_r;
        dr_next_s   = dr_r;
        ac_next_s   = ac_r;
        ir_next_s   = ir_r;
        e_next_s    = e_r;
        j_next_s    = j_r;
        s_next_s    = s_r;
        sc_next_s   = sc_e'(sc_r + 3'd1);
        sel_s       = BUS_NONE;
        en_s        = BUS_NONE;
        reg_op_s    = 8'd0;
        mem_we_s    = 1'b0;
        mem_wdata_s = 8'd0;

        if (!s_r) begin
            sc_next_s = T0;
        end else begin
            case (sc_r)
                T0: begin
                    ar_next_s = pc_r;
                    sel_s     = BUS_PC;
                    en_s      = BUS_AR;
                end
                T1: begin
                    ir_next_s = mem_rd_s;
                    pc_next_s = pc_r + 4'd1;
                    sel_s     = BUS_MEM;
                    en_s      = BUS_IR;
                end
                T2: begin
                    ar_next_s = ir_r[3:0];
                    j_next_s  = ir_r[7];
                    sel_s     = BUS_IR;
                    en_s      = BUS_AR;
                end
                T3: begin
                    if (d7_s) begin
                        sc_next_s = T0;
                        if (!j_r) begin
                            reg_op_s = 8'd1 << ir_r[2:0];
                            case (ir_r[2:0])
                                3'd0: ac_next_s = 8'd0;
                                3'd1: e_next_s  = 1'b0;
                                3'd2: ac_next_s = ~ac_r;
                                3'd3: e_next_s  = ~e_r;
                                3'd4: begin
                                    ac_next_s = {e_r, ac_r[7:1]};
                                    e_next_s  = ac_r[0];
                                end
                                3'd5: begin
                                    ac_next_s = {ac_r[6:0], e_r};
                                    e_next_s  = ac_r[7];
                                end
                                3'd6: ac_next_s = ac_r + 8'd1;
                                3'd7: s_next_s  = 1'b0;
                                default: ac_next_s = ac_r;
                            endcase
                        end else begin
                            reg_op_s = 8'd0;
                        end
                    end else if (j_r) begin
                        ar_next_s = mem_rd_s[3:0];
                        sel_s     = BUS_MEM;
                        en_s      = BUS_AR;
                    end else begin
                        sel_s = BUS_NONE;
                    end
                end
                T4: begin
                    case (ir_r[6:4])
                        OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                            dr_next_s = mem_rd_s;
                            sel_s     = BUS_MEM;
                            en_s      = BUS_DR;
                        end
                        OP_STA: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = ac_r;
                            sel_s       = BUS_AC;
                            en_s        = BUS_MWR;
                            sc_next_s   = T0;
                        end
                        OP_BUN: begin
                            pc_next_s = ar_r;
                            sel_s     = BUS_AR;
                            en_s      = BUS_PC;
                            sc_next_s = T0;
                        end
                        OP_BSA: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = {4'b0000, pc_r};
                            ar_next_s   = ar_r + 4'd1;
                            sel_s       = BUS_PC;
                            en_s        = BUS_MWR;
                        end
                        default: sc_next_s = T0;
                    endcase
                end
                T5: begin
                    sc_next_s = T0;
                    case (ir_r[6:4])
                        OP_AND: begin
                            ac_next_s = ac_r & dr_r;
                            sel_s     = BUS_DR;
                            en_s      = BUS_AC;
                        end
                        OP_ADD: begin
                            {e_next_s, ac_next_s} = sum_s;
                            sel_s                 = BUS_DR;
                            en_s                  = BUS_AC;
                        end
                        OP_LDA: begin
                            ac_next_s = dr_r;
                            sel_s     = BUS_DR;
                            en_s      = BUS_AC;
                        end
                        OP_BSA: begin
                            pc_next_s = ar_r;
                            sel_s     = BUS_AR;
                            en_s      = BUS_PC;
                        end
                        OP_ISZ: begin
                            dr_next_s = dr_r + 8'd1;
                            sc_next_s = T6;
                        end
                        default: sc_next_s = T0;
                    endcase
                end
                T6: begin
                    sc_next_s = T0;
                    if (ir_r[6:4] == OP_ISZ) begin
                        mem_we_s    = 1'b1;
                        mem_wdata_s = dr_r;
                        sel_s       = BUS_DR;
                        en_s        = BUS_MWR;
                        if (dr_r == 8'd0) begin
                            pc_next_s = pc_r + 4'd1;
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: sc_next_s = T0;
            endcase
        end
    end

    // Architectural register file and sequence counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ar_r <= 4'd0;
            pc_r <= 4'd0;
            dr_r <= 8'd0;
            ac_r <= 8'd0;
            ir_r <= 8'd0;
            e_r  <= 1'b0;
            j_r  <= 1'b0;
            s_r  <= 1'b1;
            sc_r <= T0;
        end else begin
            ar_r <= ar_next_s;
            pc_r <= pc_next_s;
            dr_r <= dr_next_s;
            ac_r <= ac_next_s;
            ir_r <= ir_next_s;
            e_r  <= e_next_s;
            j_r  <= j_next_s;
            s_r  <= s_next_s;
            sc_r <= sc_next_s;
        end
    end

    // Memory write port; reset suppresses a write scheduled for the same edge.
    always_ff @(posedge CLK) begin
        if (!RST && mem_we_s) begin
            mem_r[ar_r] <= mem_wdata_s;
        end
    end

    assign bus.DR     = dr_r;
    assign bus.AC     = ac_r;
    assign bus.IR     = ir_r;
    assign bus.MEM    = mem_rd_s;
    assign bus.PC     = pc_r;
    assign bus.AR     = ar_r;
    assign bus.Timer  = s_r ? (8'd1 << sc_r) : 8'd0;
    assign bus.D      = 8'd1 << ir_r[6:4];
    assign bus.OUTSEQ = sc_r;
    assign bus.sel    = sel_s;
    assign bus.en     = en_s;
    assign bus.I      = reg_op_s;
    assign bus.J      = j_r;
    assign bus.E      = e_r;

endmodule

// File: tb/tb_mano_main.sv
// Bench for mano_main: seven instances with different memory images, a table of
// timed expectations, and randomized run lengths checked by an instruction-level model.
module tb_mano_main;

    localparam logic [127:0] IMG_BUILTIN = 128'h0000_0000_0000_0305_0000_0000_773A_1928;
    localparam logic [127:0] IMG_LOOP    = 128'h0000_0000_0000_002B_0000_0000_0000_4018;
    localparam logic [127:0] IMGS [7] = '{
        IMG_BUILTIN,
        128'h0000_0000_0000_7F09_0000_0000_0000_77A8,   // indirect LDA
        128'h0000_0000_0000_0080_0000_7776_7273_7528,   // register ops
        128'h0000_0000_0000_0000_0000_FF00_0077_7765,   // ISZ skip
        128'h0000_0000_0000_0077_2600_0000_0000_0056,   // BSA then LDA 6
        IMG_BUILTIN,
        IMG_LOOP
    };

    typedef enum {F_DR, F_AC, F_IR, F_MEM, F_PC, F_AR, F_TIMER, F_D,
                  F_SEQ, F_SEL, F_EN, F_I, F_J, F_E} fld_e;

    typedef struct packed {
        logic [7:0] dr, ac, ir, mem;
        logic [3:0] pc, ar;
        logic [7:0] timer, d;
        logic [2:0] seq, sel, en;
        logic [7:0] i;
        logic       j, e;
    } obs_t;

    typedef struct {
        int         cyc;
        int         unit;
        fld_e       f;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic [6:0] rst = 7'h7F;
    obs_t       obs [7];
    vec_t       vecs [$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] m_mem [16];
    logic [7:0] m_ac;
    logic [3:0] m_pc;
    logic       m_e;

    mano_main_if bus [7] ();

    always #5 clk = ~clk;

    for (genvar g = 0; g < 7; g++) begin : g_dut
        if (g == 0 || g == 5) begin : g_def
            mano_main u_dut (.CLK(clk), .RST(rst[g]), .bus(bus[g]));
        end else begin : g_img
            mano_main #(.INIT_IMAGE(IMGS[g])) u_dut (.CLK(clk), .RST(rst[g]), .bus(bus[g]));
        end
        assign obs[g] = {bus[g].DR, bus[g].AC, bus[g].IR, bus[g].MEM, bus[g].PC, bus[g].AR,
                         bus[g].Timer, bus[g].D, bus[g].OUTSEQ, bus[g].sel, bus[g].en,
                         bus[g].I, bus[g].J, bus[g].E};
    end

    function automatic logic [7:0] get(int u, fld_e f);
        obs_t o = obs[u];
        case (f)
            F_DR:    return o.dr;
            F_AC:    return o.ac;
            F_IR:    return o.ir;
            F_MEM:   return o.mem;
            F_PC:    return {4'd0, o.pc};
            F_AR:    return {4'd0, o.ar};
            F_TIMER: return o.timer;
            F_D:     return o.d;
            F_SEQ:   return {5'd0, o.seq};
            F_SEL:   return {5'd0, o.sel};
            F_EN:    return {5'd0, o.en};
            F_I:     return o.i;
            F_J:     return {7'd0, o.j};
            default: return {7'd0, o.e};
        endcase
    endfunction

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
        end
    endtask

    task automatic add(int c, int u, fld_e f, logic [7:0] x);
        vecs.push_back('{cyc: c, unit: u, f: f, exp: x});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Shared timeline: unit 5 is reset across the edge that would end ADD's T4.
    task automatic step();
        tick();
        cyc++;
        if (cyc == 10) rst[5] = 1'b1;
        if (cyc == 11) rst[5] = 1'b0;
    endtask

    // Instruction-level model: executes one whole instruction, returns its cycle count.
    task automatic model_exec(output int n);
        logic [7:0] w, v;
        logic [3:0] ea;
        logic [8:0] s;
        w    = m_mem[m_pc];
        m_pc = m_pc + 4'd1;
        ea   = w[7] ? m_mem[w[3:0]][3:0] : w[3:0];
        v    = m_mem[ea];
        case (w[6:4])
            3'd0: begin m_ac = m_ac & v; n = 6; end
            3'd1: begin s = {1'b0, m_ac} + {1'b0, v}; m_ac = s[7:0]; m_e = s[8]; n = 6; end
            3'd2: begin m_ac = v; n = 6; end
            3'd3: begin m_mem[ea] = m_ac; n = 5; end
            3'd4: begin m_pc = ea; n = 5; end
            3'd5: begin m_mem[ea] = {4'd0, m_pc}; m_pc = ea + 4'd1; n = 6; end
            3'd6: begin m_mem[ea] = v + 8'd1; if (m_mem[ea] == 8'd0) m_pc = m_pc + 4'd1; n = 7; end
            default: n = 4;
        endcase
    endtask

    initial begin
        int k, total, n, r;

        // built-in program (unit 0)
        add(0, 0, F_TIMER, 8'h01); add(0, 0, F_SEL, 8'h02); add(0, 0, F_EN, 8'h01);
        add(0, 0, F_AC, 8'h00);    add(0, 0, F_PC, 8'h00);  add(0, 0, F_IR, 8'h00);
        add(1, 0, F_TIMER, 8'h02); add(1, 0, F_AR, 8'h00);  add(1, 0, F_SEL, 8'h07);
        add(1, 0, F_EN, 8'h05);
        add(2, 0, F_IR, 8'h28);    add(2, 0, F_PC, 8'h01);  add(2, 0, F_SEL, 8'h05);
        add(2, 0, F_EN, 8'h01);
        // indirect LDA (unit 1)
        add(3, 1, F_AR, 8'h08);    add(3, 1, F_J, 8'h01);   add(3, 1, F_SEL, 8'h07);
        add(3, 1, F_EN, 8'h01);    add(3, 1, F_D, 8'h04);   add(3, 1, F_MEM, 8'h09);
        add(4, 1, F_AR, 8'h09);
        add(6, 1, F_AC, 8'h7F);    add(6, 4, F_PC, 8'h07);
        add(7, 3, F_PC, 8'h02);    add(7, 3, F_MEM, 8'h00); add(7, 3, F_TIMER, 8'h01);
        add(9, 2, F_I, 8'h20);
        add(10, 2, F_AC, 8'h00);   add(10, 2, F_E, 8'h01);
        add(10, 5, F_TIMER, 8'h10); add(10, 5, F_DR, 8'h05);
        // unit 5 right after reset hit mid-ADD
        add(11, 5, F_AC, 8'h00);   add(11, 5, F_DR, 8'h00); add(11, 5, F_IR, 8'h00);
        add(11, 5, F_PC, 8'h00);   add(11, 5, F_AR, 8'h00); add(11, 5, F_E, 8'h00);
        add(11, 5, F_J, 8'h00);    add(11, 5, F_SEQ, 8'h00); add(11, 5, F_TIMER, 8'h01);
        add(11, 5, F_MEM, 8'h28);
        add(12, 0, F_AC, 8'h08);   add(12, 0, F_E, 8'h00);  add(12, 4, F_AC, 8'h01);
        add(14, 2, F_E, 8'h00);
        add(17, 0, F_MEM, 8'h08);  add(17, 0, F_AR, 8'h0A); add(17, 0, F_PC, 8'h03);
        add(18, 2, F_AC, 8'hFF);
        add(21, 0, F_TIMER, 8'h00); add(21, 0, F_PC, 8'h04); add(21, 0, F_AC, 8'h08);
        add(21, 0, F_SEL, 8'h00);  add(21, 0, F_EN, 8'h00); add(21, 0, F_SEQ, 8'h00);
        add(21, 0, F_E, 8'h00);
        add(22, 2, F_AC, 8'h00);   add(22, 2, F_E, 8'h00);
        add(26, 2, F_TIMER, 8'h00); add(26, 2, F_I, 8'h00);
        add(30, 0, F_AC, 8'h08);   add(30, 0, F_TIMER, 8'h00); add(30, 0, F_PC, 8'h04);
        add(32, 5, F_AC, 8'h08);   add(32, 5, F_TIMER, 8'h00); add(32, 5, F_PC, 8'h04);

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst[5:0] = 6'd0;
        for (int v = 0; v < vecs.size(); v++) begin
            while (cyc < vecs[v].cyc) step();
            check($sformatf("u%0d_%s_c%0d", vecs[v].unit, vecs[v].f.name(), vecs[v].cyc),
                  get(vecs[v].unit, vecs[v].f), vecs[v].exp);
        end

        // randomized run lengths and reset points on the ADD/BUN loop (unit 6)
        for (int m = 0; m < 16; m++) m_mem[m] = IMG_LOOP[8*m +: 8];
        for (int t = 0; t < 10; t++) begin
            rst[6] = 1'b1;
            tick();
            rst[6] = 1'b0;
            check($sformatf("rnd%0d_rst_timer", t), get(6, F_TIMER), 8'h01);
            check($sformatf("rnd%0d_rst_ac", t), get(6, F_AC), 8'h00);
            m_ac = 8'd0; m_pc = 4'd0; m_e = 1'b0;
            k = $urandom_range(1, 12);
            total = 0;
            repeat (k) begin
                model_exec(n);
                total += n;
            end
            repeat (total) tick();
            check($sformatf("rnd%0d_k%0d_timer", t, k), get(6, F_TIMER), 8'h01);
            check($sformatf("rnd%0d_k%0d_ac", t, k), get(6, F_AC), m_ac);
            check($sformatf("rnd%0d_k%0d_e", t, k), get(6, F_E), {7'd0, m_e});
            check($sformatf("rnd%0d_k%0d_pc", t, k), get(6, F_PC), {4'd0, m_pc});
            r = $urandom_range(0, 10);
            repeat (r) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
